// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the game-score counter
package score_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        LOST    = 2'd2
    } state_t;

    localparam int          BCD_DIGITS            = 4;
    localparam int          BCD_W                 = BCD_DIGITS * 4;
    localparam logic [15:0] SCORE_MAX_BCD_DEFAULT = 16'h9999;

endpackage

// File: rtl/bcd_inc4.sv
// rtl/bcd_inc4.sv - combinational four-digit packed BCD increment
// Ports:
//   value_i   : packed BCD input, [15:12] = thousands
//   value_o   : value_i + 1 in BCD, wraps to 0000 from 9999
//   carry_out : 1 when value_i was 9999 (carry out of the top digit)
module bcd_inc4
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] value_i,
    output logic [BCD_W-1:0] value_o,
    output logic             carry_out
);

    logic       carry;
    logic [3:0] digit;

    // Ripple the +1 up the digits; a 9 rolls to 0 and passes the carry on.
    always_comb begin
        value_o = value_i;
        carry   = 1'b1;
        digit   = 4'd0;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            digit = value_i[d*4 +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    value_o[d*4 +: 4] = 4'd0;
                end else begin
                    value_o[d*4 +: 4] = digit + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        carry_out = carry;
    end

endmodule

// File: rtl/score_bcd_counter.sv
// rtl/score_bcd_counter.sv - run score, session high score and lost/blink sequencing
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   start       : rising edge starts a run (from IDLE or LOST)
//   pipe_passed : rising edge adds one point while PLAYING
//   crash       : level, ends the run while PLAYING
//   score_bcd   : current run score, 4 packed BCD digits
//   high_bcd    : best score since reset
//   disp_bcd    : high_bcd in IDLE, score_bcd otherwise
//   lost        : high while in LOST
//   blink_on    : display enable, blinks while in LOST
//   saturated   : score_bcd has reached SCORE_MAX_BCD
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int          BLINK_DIV     = 50000000,
    parameter logic [15:0] SCORE_MAX_BCD = SCORE_MAX_BCD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pipe_passed,
    input  logic             crash,
    output logic [BCD_W-1:0] score_bcd,
    output logic [BCD_W-1:0] high_bcd,
    output logic [BCD_W-1:0] disp_bcd,
    output logic             lost,
    output logic             blink_on,
    output logic             saturated
);

    localparam int               CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    state_t           state_q, state_d;
    logic             start_q, pipe_q;
    logic [BCD_W-1:0] score_q, score_d;
    logic [BCD_W-1:0] high_q, high_d;
    logic [BCD_W-1:0] disp_q, disp_d;
    logic             lost_q;
    logic             blink_q, blink_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             start_rise, pipe_rise;
    logic [BCD_W-1:0] score_inc;
    logic             inc_carry;
    logic             can_inc;

    bcd_inc4 u_inc (
        .value_i   (score_q),
        .value_o   (score_inc),
        .carry_out (inc_carry)
    );

    assign start_rise = start & ~start_q;
    assign pipe_rise  = pipe_passed & ~pipe_q;
    // Holding at the maximum stops the BCD adder from wrapping to 0000.
    assign can_inc    = ~inc_carry && (score_q != SCORE_MAX_BCD);

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        cnt_d   = '0;
        blink_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = PLAYING;
                    score_d = '0;
                end
            end
            PLAYING: begin
                if (pipe_rise && can_inc) begin
                    score_d = score_inc;
                end
                // A point arriving with the crash still counts toward the high score.
                if (crash) begin
                    state_d = LOST;
                    if (score_d > high_q) begin
                        high_d = score_d;
                    end
                end
            end
            LOST: begin
                if (start_rise) begin
                    state_d = PLAYING;
                    score_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering LOST blanks the display at once; afterwards toggle every BLINK_DIV cycles.
        if (state_d == LOST) begin
            if (state_q != LOST) begin
                cnt_d   = '0;
                blink_d = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                blink_d = blink_q;
            end
        end

        disp_d = (state_d == IDLE) ? high_d : score_d;
        sat_d  = (score_d == SCORE_MAX_BCD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            pipe_q  <= 1'b0;
            score_q <= '0;
            high_q  <= '0;
            disp_q  <= '0;
            lost_q  <= 1'b0;
            blink_q <= 1'b1;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            pipe_q  <= pipe_passed;
            score_q <= score_d;
            high_q  <= high_d;
            disp_q  <= disp_d;
            lost_q  <= (state_d == LOST);
            blink_q <= blink_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign disp_bcd  = disp_q;
    assign lost      = lost_q;
    assign blink_on  = blink_q;
    assign saturated = sat_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
// tb/tb_score_bcd_counter.sv - self-checking bench for score_bcd_counter
module tb_score_bcd_counter;

    localparam int BLINK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst, start, pipe_passed, crash;
    logic [15:0] score_bcd, high_bcd, disp_bcd;
    logic        lost, blink_on, saturated;

    int checks = 0;
    int errors = 0;

    // Reference model: decimal integers and a phase name, not BCD registers.
    int m_phase;   // 0 idle, 1 playing, 2 lost
    int m_score, m_high, m_lost_cycles;
    bit m_prev_start, m_prev_pipe;

    score_bcd_counter #(.BLINK_DIV(BLINK_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pipe_passed (pipe_passed),
        .crash       (crash),
        .score_bcd   (score_bcd),
        .high_bcd    (high_bcd),
        .disp_bcd    (disp_bcd),
        .lost        (lost),
        .blink_on    (blink_on),
        .saturated   (saturated)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit s_rise, p_rise;
        if (rst) begin
            m_phase = 0; m_score = 0; m_high = 0; m_lost_cycles = 0;
            m_prev_start = 0; m_prev_pipe = 0;
        end else begin
            s_rise = start && !m_prev_start;
            p_rise = pipe_passed && !m_prev_pipe;
            m_prev_start = start;
            m_prev_pipe  = pipe_passed;
            case (m_phase)
                0: if (s_rise) begin m_phase = 1; m_score = 0; end
                1: begin
                    if (p_rise && m_score < 9999) m_score++;
                    if (crash) begin
                        m_phase = 2;
                        m_lost_cycles = 0;
                        if (m_score > m_high) m_high = m_score;
                    end
                end
                default: begin
                    if (s_rise) begin m_phase = 1; m_score = 0; end
                    else m_lost_cycles++;
                end
            endcase
        end
    endtask

    task automatic check_all();
        chk("score", score_bcd, to_bcd(m_score));
        chk("high", high_bcd, to_bcd(m_high));
        chk("disp", disp_bcd, (m_phase == 0) ? to_bcd(m_high) : to_bcd(m_score));
        chk("lost", {15'd0, lost}, {15'd0, m_phase == 2});
        chk("blink", {15'd0, blink_on},
            {15'd0, (m_phase != 2) || ((m_lost_cycles / BLINK_DIV) % 2 == 1)});
        chk("sat", {15'd0, saturated}, {15'd0, m_score == 9999});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1; tick();
        start = 1'b0; tick();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pipe_passed = 1'b1; tick();
            pipe_passed = 1'b0; tick();
        end
    endtask

    task automatic do_crash();
        crash = 1'b1; tick();
        crash = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pipe_passed = 1'b0; crash = 1'b0;
        m_phase = 0; m_score = 0; m_high = 0; m_lost_cycles = 0;
        m_prev_start = 0; m_prev_pipe = 0;

        // Reset state and basic counting with a 9 -> 10 carry
        do_reset();
        chk("reset_disp", disp_bcd, 16'h0000);
        chk("reset_blink", {15'd0, blink_on}, 16'h0001);
        press_start();
        pulses(12);
        chk("score_12", score_bcd, 16'h0012);
        chk("disp_12", disp_bcd, 16'h0012);

        // Held level counts once, then a 99 -> 100 carry
        pipe_passed = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        pipe_passed = 1'b0; tick();
        chk("held_once", score_bcd, 16'h0013);
        pulses(86);
        chk("score_99", score_bcd, 16'h0099);
        pulses(1);
        chk("score_100", score_bcd, 16'h0100);

        // Crash, high score capture and blink cadence
        do_reset();
        press_start();
        pulses(7);
        do_crash();
        chk("lost_7", {15'd0, lost}, 16'h0001);
        chk("high_7", high_bcd, 16'h0007);
        chk("blink_dark", {15'd0, blink_on}, 16'h0000);
        for (int i = 0; i < 3 * BLINK_DIV; i++) tick();
        press_start();
        pulses(5);
        do_crash();
        chk("high_keeps_7", high_bcd, 16'h0007);

        // Point and crash on the same edge
        press_start();
        pulses(41);
        pipe_passed = 1'b1; crash = 1'b1; tick();
        pipe_passed = 1'b0; crash = 1'b0; tick();
        chk("same_edge_score", score_bcd, 16'h0042);
        chk("same_edge_high", high_bcd, 16'h0042);
        do_reset();
        chk("idle_disp_zero", disp_bcd, 16'h0000);

        // Saturation at 9999
        press_start();
        pulses(9998);
        chk("score_9998", score_bcd, 16'h9998);
        pulses(3);
        chk("score_sat", score_bcd, 16'h9999);
        chk("sat_flag", {15'd0, saturated}, 16'h0001);

        // Reset in LOST clears everything and needs a fresh start
        do_crash();
        tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rst_high", high_bcd, 16'h0000);
        chk("rst_lost", {15'd0, lost}, 16'h0000);
        pulses(3);
        chk("no_start_no_count", score_bcd, 16'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 599) == 0);
            start       = ($urandom_range(0, 24) == 0);
            pipe_passed = $urandom_range(0, 1);
            crash       = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
